// File: rtl/music_box_pkg.sv
// music_box_pkg: shared widths, song memory geometry and responder state encoding.
package music_box_pkg;
  localparam int SONG_WORD_W   = 16;
  localparam int SONG_DEPTH    = 512;
  localparam int CHANNEL_WORDS = 6;
  typedef enum logic {CLEAR, READY} state_t;
endpackage

// File: rtl/song_memory_array.sv
// song_memory_array: simple dual-port synchronous RAM, 1-cycle read, read-before-write, contents not reset.
module song_memory_array #(
  parameter int DEPTH = 512,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [DEPTH];
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/song_memory_responder.sv
// song_memory_responder: clears song RAM after reset, then serves pipelined range-checked reads and load-port writes.
module song_memory_responder
  import music_box_pkg::*;
#(
  parameter int DEPTH         = SONG_DEPTH,
  parameter int CHANNEL_WORDS = music_box_pkg::CHANNEL_WORDS
) (
  input  logic                   clock_50Mhz,
  input  logic                   reset,
  input  logic                   rd_req,
  input  logic [15:0]            rd_index,
  input  logic [15:0]            rd_index_max,
  output logic                   rd_ready,
  output logic [SONG_WORD_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic                   rd_error,
  input  logic                   wr_en,
  input  logic [15:0]            wr_index,
  input  logic [SONG_WORD_W-1:0] wr_data,
  output logic                   wr_ack,
  output logic                   busy
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [16:0] DEPTH_X = 17'(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
  if (CHANNEL_WORDS < 1 || DEPTH < 2) begin : g_bad_cfg
    $error("song_memory_responder: invalid CHANNEL_WORDS/DEPTH");
  end
  state_t                 r_state;
  logic [AW-1:0]          r_cnt;
  logic                   r_p1_valid, r_p1_err, r_p2_valid, r_p2_err;
  logic [SONG_WORD_W-1:0] r_p2_data;
  logic [SONG_WORD_W-1:0] w_q;
  logic                   w_clr, w_accept, w_in_range, w_wr_ok;
  assign w_clr      = r_state == CLEAR;
  assign w_accept   = rd_req && !w_clr;
  // bound = min(rd_index_max, DEPTH), evaluated on the accept cycle
  assign w_in_range = ({1'b0, rd_index} < DEPTH_X) && (rd_index < rd_index_max);
  assign w_wr_ok    = wr_en && !w_clr && ({1'b0, wr_index} < DEPTH_X);
  assign busy       = w_clr;
  assign rd_ready   = !w_clr;
  song_memory_array #(.DEPTH(DEPTH), .W(SONG_WORD_W), .AW(AW)) u_mem (
    .i_clk  (clock_50Mhz),
    .i_we   (w_clr || w_wr_ok),
    .i_waddr(w_clr ? r_cnt : wr_index[AW-1:0]),
    .i_wdata(w_clr ? '0 : wr_data),
    .i_re   (w_accept && w_in_range),
    .i_raddr(rd_index[AW-1:0]),
    .o_rdata(w_q)
  );
  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      r_state    <= CLEAR;
      r_cnt      <= '0;
      r_p1_valid <= 1'b0;
      r_p1_err   <= 1'b0;
      r_p2_valid <= 1'b0;
      r_p2_err   <= 1'b0;
      r_p2_data  <= '0;
      rd_valid   <= 1'b0;
      rd_error   <= 1'b0;
      rd_data    <= '0;
      wr_ack     <= 1'b0;
    end else begin
      if (w_clr) begin
        r_cnt   <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        r_state <= (r_cnt == LAST) ? READY : CLEAR;
      end
      r_p1_valid <= w_accept;
      r_p1_err   <= w_accept && !w_in_range;
      r_p2_valid <= r_p1_valid;
      r_p2_err   <= r_p1_err;
      r_p2_data  <= (r_p1_valid && !r_p1_err) ? w_q : '0;
      rd_valid   <= r_p2_valid;
      rd_error   <= r_p2_err;
      rd_data    <= r_p2_data;
      wr_ack     <= w_wr_ok;
    end
  end
endmodule

// File: tb/tb_song_memory_responder.sv
// tb_song_memory_responder: directed and random stimulus checked against a cycle-stamped behavioural model.
module tb_song_memory_responder;
  localparam int DEPTH = 512;
  logic        clk = 1'b0, reset = 1'b0, rd_req = 1'b0, wr_en = 1'b0;
  logic [15:0] rd_index = '0, rd_index_max = '0, wr_index = '0, wr_data = '0;
  logic        rd_ready, rd_valid, rd_error, wr_ack, busy;
  logic [15:0] rd_data;
  int total = 0, bad = 0, ec = 0, m_clr = 0;
  logic [15:0] mem [DEPTH];
  logic exp_ack = 1'b0;
  typedef struct {int due; logic err; logic [15:0] d;} rsp_t;
  rsp_t q[$];
  song_memory_responder dut (
    .clock_50Mhz(clk), .reset(reset), .rd_req(rd_req), .rd_index(rd_index),
    .rd_index_max(rd_index_max), .rd_ready(rd_ready), .rd_data(rd_data),
    .rd_valid(rd_valid), .rd_error(rd_error), .wr_en(wr_en), .wr_index(wr_index),
    .wr_data(wr_data), .wr_ack(wr_ack), .busy(busy)
  );
  always #10 clk = ~clk;
  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s at edge %0d: observed=%h expected=%h", tag, ec, obs, exp);
    end
  endtask
  task automatic check_outputs();
    logic ev, ee;
    logic [15:0] ed;
    ev = 1'b0; ee = 1'b0; ed = '0;
    if (q.size() > 0 && q[0].due == ec) begin
      ev = 1'b1; ee = q[0].err; ed = q[0].d;
      void'(q.pop_front());
    end
    chk("rd_valid", 16'(rd_valid), 16'(ev));
    chk("rd_error", 16'(rd_error), 16'(ee));
    chk("rd_data", rd_data, ed);
    chk("wr_ack", 16'(wr_ack), 16'(exp_ack));
    chk("busy", 16'(busy), 16'(m_clr < DEPTH));
    chk("rd_ready", 16'(rd_ready), 16'(m_clr >= DEPTH));
  endtask
  task automatic check_idle();
    chk("rst_rd_valid", 16'(rd_valid), 16'd0);
    chk("rst_rd_error", 16'(rd_error), 16'd0);
    chk("rst_rd_data", rd_data, 16'd0);
    chk("rst_wr_ack", 16'(wr_ack), 16'd0);
    chk("rst_busy", 16'(busy), 16'd1);
    chk("rst_rd_ready", 16'(rd_ready), 16'd0);
  endtask
  // Model one clock edge from the inputs currently presented, then check outputs just after it.
  task automatic tick();
    int bound;
    rsp_t r;
    exp_ack = 1'b0;
    if (m_clr < DEPTH) m_clr++;
    else begin
      if (rd_req) begin
        bound = (int'(rd_index_max) < DEPTH) ? int'(rd_index_max) : DEPTH;
        r.due = ec + 3;
        r.err = int'(rd_index) >= bound;
        r.d   = r.err ? 16'h0000 : mem[rd_index[8:0]];
        q.push_back(r);
      end
      if (wr_en && int'(wr_index) < DEPTH) begin
        mem[wr_index[8:0]] = wr_data;
        exp_ack = 1'b1;
      end
    end
    @(posedge clk);
    ec++;
    #1;
    check_outputs();
  endtask
  task automatic do_reset(int n);
    reset = 1'b1;
    q.delete();
    m_clr = 0;
    exp_ack = 1'b0;
    foreach (mem[i]) mem[i] = '0;
    #1;
    check_idle();
    repeat (n) begin
      @(posedge clk);
      ec++;
      #1;
      check_idle();
    end
    reset = 1'b0;
  endtask
  task automatic set_rd(logic req, logic [15:0] idx, logic [15:0] mx);
    rd_req = req; rd_index = idx; rd_index_max = mx;
  endtask
  task automatic set_wr(logic en, logic [15:0] idx, logic [15:0] d);
    wr_en = en; wr_index = idx; wr_data = d;
  endtask
  task automatic idle(int n);
    set_rd(1'b0, '0, '0);
    set_wr(1'b0, '0, '0);
    repeat (n) tick();
  endtask
  task automatic rand_inputs();
    int k;
    k = $urandom_range(0, 4);
    rd_req       = 1'($urandom_range(0, 1));
    rd_index     = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 700)) : 16'($urandom_range(0, 31));
    rd_index_max = (k == 0) ? 16'd512 : (k == 1) ? 16'hFFFF : (k == 2) ? 16'd0 :
                   (k == 3) ? 16'd20 : 16'($urandom_range(0, 600));
    wr_en        = ($urandom_range(0, 2) == 0);
    wr_index     = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 700)) : 16'($urandom_range(0, 31));
    wr_data      = 16'($urandom);
  endtask
  initial begin
    #2;
    do_reset(3);
    idle(DEPTH);
    set_rd(1'b1, 16'd7, 16'd512); tick();
    idle(3);
    set_wr(1'b1, 16'd6, 16'h1A2B); tick();
    idle(1);
    set_rd(1'b1, 16'd6, 16'd512); tick();
    idle(3);
    for (int i = 0; i < 3; i++) begin
      set_rd(1'b1, 16'(i), 16'd512); tick();
    end
    idle(3);
    set_rd(1'b1, 16'd184, 16'd184); tick();
    set_rd(1'b1, 16'd183, 16'd184); tick();
    set_rd(1'b1, 16'd511, 16'hFFFF); tick();
    set_rd(1'b1, 16'd512, 16'hFFFF); tick();
    set_rd(1'b1, 16'd0, 16'd0); tick();
    idle(3);
    set_wr(1'b1, 16'd600, 16'hBEEF); tick();
    set_wr(1'b0, '0, '0);
    set_rd(1'b1, 16'd88, 16'd512); tick();
    idle(3);
    set_wr(1'b1, 16'd10, 16'h0005); tick();
    set_wr(1'b1, 16'd10, 16'h00FF);
    set_rd(1'b1, 16'd10, 16'd512); tick();
    set_wr(1'b0, '0, '0);
    set_rd(1'b1, 16'd10, 16'd512); tick();
    idle(3);
    repeat (600) begin
      rand_inputs();
      tick();
    end
    idle(3);
    set_rd(1'b1, 16'd10, 16'd512); tick();
    idle(1);
    do_reset(2);
    repeat (100) begin
      rand_inputs();
      tick();
    end
    idle(0);
    do_reset(1);
    idle(DEPTH);
    set_rd(1'b1, 16'd10, 16'd512); tick();
    idle(3);
    repeat (300) begin
      rand_inputs();
      tick();
    end
    idle(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/song_memory_responder.md
SONG_MEMORY_RESPONDER -- requirements
Module: song_memory_responder

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset (clock_50Mhz, reset).
REQ-002 Parameter DEPTH SHALL default to 512 and set the number of 16-bit song words stored.
REQ-003 Parameter CHANNEL_WORDS SHALL default to 6 and set the words per song step (3 channels x frequency/amplitude pair).
REQ-004 clock_50Mhz  in  1  system clock; all state updates on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rd_req  in  1  read request, sampled only while rd_ready=1.
REQ-007 rd_index  in  16  word address requested by the player.
REQ-008 rd_index_max  in  16  player-declared song length in words (exclusive bound).
REQ-009 rd_ready  out  1  responder can accept a read this cycle.
REQ-010 rd_data  out  16  returned word, valid only when rd_valid=1.
REQ-011 rd_valid  out  1  one-cycle pulse per accepted read.
REQ-012 rd_error  out  1  qualifies rd_valid; 1 = index was out of range.
REQ-013 wr_en  in  1  load-port write strobe.
REQ-014 wr_index  in  16  load-port word address.
REQ-015 wr_data  in  16  load-port word.
REQ-016 wr_ack  out  1  one-cycle pulse, write committed.
REQ-017 busy  out  1  1 while clearing memory.

Function
REQ-018 States: CLEAR, READY; reset enters CLEAR.
REQ-019 CLEAR: write 0 to addresses 0..DEPTH-1, one per cycle, via an internal counter; after address DEPTH-1 go to READY (DEPTH cycles total).
REQ-020 busy=1 and rd_ready=0 in CLEAR; busy=0 and rd_ready=1 in READY.
REQ-021 wr_en in CLEAR: ignored, no wr_ack.
REQ-022 Read accepted when rd_req=1 and rd_ready=1; one accept per cycle, fully pipelined.
REQ-023 Read latency exactly 2 cycles: accept at edge N, rd_valid=1 for the cycle following edge N+2.
REQ-024 Bound = min(rd_index_max, DEPTH), captured at accept.
REQ-025 rd_index >= bound: rd_data=0 and rd_error=1 with rd_valid; memory not read.
REQ-026 rd_index_max=0: every read returns error.
REQ-027 In range: rd_data = stored word, rd_error=0.
REQ-028 wr_en in READY with wr_index<DEPTH: commit at that edge, wr_ack pulses next cycle.
REQ-029 wr_index >= DEPTH: no write, no wr_ack.
REQ-030 Same-cycle read accept and write to the same address: read returns old data (read-before-write).
REQ-031 Reads in flight at a CLEAR entry (reset) are discarded; no rd_valid.
REQ-032 rd_data held at 0 whenever rd_valid=0.

Reset
REQ-033 During and immediately after reset: rd_valid=0, rd_error=0, rd_data=0, wr_ack=0, rd_ready=0, busy=1, clear counter=0.
REQ-034 Reset asserted mid-read or mid-clear restarts CLEAR from address 0; pipeline flushed.

Structure
REQ-035 Package music_box_pkg SHALL hold SONG_WORD_W=16, SONG_DEPTH=512, CHANNEL_WORDS=6, and the state enum {CLEAR, READY}.
REQ-036 Storage SHALL be one sub-module song_memory_array: simple dual-port synchronous RAM, 1-cycle read, read-before-write, no reset on contents.
REQ-037 Range check, valid/error pipeline, and clear counter SHALL reside in the top module.

Verification
REQ-038 Reset release, no stimulus -> busy=1 for 512 cycles, then rd_ready=1; read index 7 -> rd_data=0x0000, rd_error=0.
REQ-039 Write 0x1A2B to index 6 -> wr_ack one cycle later; read index 6 with max 512 -> rd_valid 2 cycles after accept, rd_data=0x1A2B.
REQ-040 Back-to-back reads of 0,1,2 in consecutive cycles -> three consecutive rd_valid pulses in order with matching data.
REQ-041 Read index 184 with rd_index_max=184 -> rd_valid=1, rd_error=1, rd_data=0; write to index 600 -> no wr_ack, memory unchanged.
REQ-042 Same-cycle read and write of index 10 (old 0x0005, new 0x00FF) -> read returns 0x0005; next read returns 0x00FF.
REQ-043 Reset asserted one cycle after read accept -> no rd_valid; CLEAR restarts; index 10 reads 0 afterward.
